// File: rtl/bus_arbiter.sv
// Two-master (imem/dmem), five-slave bus arbiter with address decode and one-at-a-time sequencing.
// Optional slave-wait timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_arbiter #(
  parameter logic [31:0] ROM_BASE       = 32'h0,
  parameter logic [31:0] ROM_TOP        = 32'h80,
  parameter logic [31:0] PRINT_BASE     = 32'h1000000,
  parameter logic [31:0] PRINT_TOP      = 32'h1000004,
  parameter logic [31:0] CLINT_BASE     = 32'h2000000,
  parameter logic [31:0] CLINT_TOP      = 32'h200C000,
  parameter logic [31:0] CLIC_BASE      = 32'h3000000,
  parameter logic [31:0] CLIC_TOP       = 32'h3005000,
  parameter logic [31:0] BRAM_BASE      = 32'h80000000,
  parameter logic [31:0] BRAM_TOP       = 32'h90000000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         imem_valid,
  input  logic [31:0]  imem_addr,
  output logic         imem_ready,
  output logic [31:0]  imem_rdata,
  output logic         imem_error,
  input  logic         dmem_valid,
  input  logic [31:0]  dmem_addr,
  input  logic [31:0]  dmem_wdata,
  input  logic [3:0]   dmem_wstrb,
  output logic         dmem_ready,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_error,
  output logic [4:0]   s_valid,
  output logic         s_instr,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic [3:0]   s_wstrb,
  input  logic [4:0]   s_ready,
  input  logic [159:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_dmem_q, last_dmem_d;
  logic        grant_dmem_q, grant_dmem_d;
  logic        instr_q, instr_d;
  logic        error_q, error_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  sel_q, sel_d;

  logic        pick_dmem;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [4:0]  req_hit;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Offset compare: a wrapped (addr - base) for addr < base lands above the region size.
  function automatic logic in_region(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] t);
    return (a - b) < (t - b);
  endfunction

  always_comb begin
    pick_dmem  = dmem_valid && (!imem_valid || !last_dmem_q);
    req_addr   = pick_dmem ? dmem_addr  : imem_addr;
    req_wstrb  = pick_dmem ? dmem_wstrb : '0;
    req_hit[0] = in_region(req_addr, ROM_BASE,   ROM_TOP);
    req_hit[1] = in_region(req_addr, PRINT_BASE, PRINT_TOP);
    req_hit[2] = in_region(req_addr, CLINT_BASE, CLINT_TOP);
    req_hit[3] = in_region(req_addr, CLIC_BASE,  CLIC_TOP);
    req_hit[4] = in_region(req_addr, BRAM_BASE,  BRAM_TOP);
  end

  always_comb begin
    sel_ready = |(s_ready & sel_q);
    sel_rdata = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned      CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY && !sel_ready) cnt_d = cnt_q + CW'(1);
  end

  // Expires on the cycle the count would reach TIMEOUT_CYCLES, so s_valid is high exactly that long.
  assign timeout = (state_q == BUSY) && !sel_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_dmem_d  = last_dmem_q;
    grant_dmem_d = grant_dmem_q;
    instr_d      = instr_q;
    error_d      = error_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wstrb_d      = wstrb_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          grant_dmem_d = pick_dmem;
          last_dmem_d  = pick_dmem;
          instr_d      = !pick_dmem;
          addr_d       = req_addr;
          wdata_d      = pick_dmem ? dmem_wdata : '0;
          wstrb_d      = req_wstrb;
          rdata_d      = '0;
          error_d      = 1'b0;
          if (req_hit == '0 || (req_hit[0] && req_wstrb != '0)) begin
            sel_d   = '0;
            state_d = ERR;
          end else begin
            sel_d   = req_hit;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          error_d = 1'b0;
          state_d = RESP;
        end else if (timeout) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = RESP;
        end
      end
      ERR: begin
        rdata_d = '0;
        error_d = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_dmem_q  <= 1'b0;
      grant_dmem_q <= 1'b0;
      instr_q      <= 1'b0;
      error_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_dmem_q  <= last_dmem_d;
      grant_dmem_q <= grant_dmem_d;
      instr_q      <= instr_d;
      error_q      <= error_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      wstrb_q      <= wstrb_d;
      sel_q        <= sel_d;
    end
  end

  assign s_valid    = (state_q == BUSY) ? sel_q : '0;
  assign s_instr    = instr_q;
  assign s_addr     = addr_q;
  assign s_wdata    = wdata_q;
  assign s_wstrb    = wstrb_q;
  assign imem_ready = (state_q == RESP) && !grant_dmem_q;
  assign dmem_ready = (state_q == RESP) && grant_dmem_q;
  assign imem_rdata = imem_ready ? rdata_q : '0;
  assign imem_error = imem_ready && error_q;
  assign dmem_rdata = dmem_ready ? rdata_q : '0;
  assign dmem_error = dmem_ready && error_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus hand sequences, responses via scoreboard queue.
// Define BUS_TIMEOUT_EN for both files to exercise the timeout path.
module tb_bus_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         imem_valid, imem_ready, imem_error;
  logic [31:0]  imem_addr, imem_rdata;
  logic         dmem_valid, dmem_ready, dmem_error;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_wstrb;
  logic [4:0]   s_valid, s_ready;
  logic         s_instr;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [159:0] s_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_dmem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned delay;
    logic [31:0] srdata;
    logic [4:0]  exp_sel;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_dmem;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[15];

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Response monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clock) begin : monitor
    sb_t e;
    if (!reset && (imem_ready || dmem_ready)) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got imem=%0b dmem=%0b expected none", imem_ready, dmem_ready);
      end else begin
        e = sb_q.pop_front();
        check("ready_master", {62'd0, imem_ready, dmem_ready}, e.is_dmem ? 64'd1 : 64'd2);
        if (e.is_dmem) begin
          check("dmem_rdata", 64'(dmem_rdata), 64'(e.rdata));
          check("dmem_error", 64'(dmem_error), 64'(e.err));
          check("imem_idle_out", {31'd0, imem_error, imem_rdata}, 64'd0);
        end else begin
          check("imem_rdata", 64'(imem_rdata), 64'(e.rdata));
          check("imem_error", 64'(imem_error), 64'(e.err));
          check("dmem_idle_out", {31'd0, dmem_error, dmem_rdata}, 64'd0);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned cyc, sv_bad, exp_lat;
    logic        seen;
    logic [4:0]  exp_sv;
    sb_t         e;
    for (int j = 0; j < 5; j++) s_rdata[32*j +: 32] = 32'hA5A50000 | 32'(j);
    for (int j = 0; j < 5; j++) if (v.exp_sel[j]) s_rdata[32*j +: 32] = v.srdata;
    imem_valid = !v.is_dmem;
    imem_addr  = v.addr;
    dmem_valid = v.is_dmem;
    dmem_addr  = v.addr;
    dmem_wdata = v.wdata;
    dmem_wstrb = v.wstrb;
    s_ready    = ~v.exp_sel;
    e.is_dmem  = v.is_dmem;
    e.rdata    = v.exp_err ? 32'h0 : v.srdata;
    e.err      = v.exp_err;
    sb_q.push_back(e);
    exp_lat = v.exp_err ? 2 : v.delay + 2;
    cyc = 0; sv_bad = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      exp_sv = (!v.exp_err && cyc <= v.delay + 1) ? v.exp_sel : 5'b0;
      if (s_valid !== exp_sv) sv_bad++;
      if (cyc == 1 && !v.exp_err) begin
        check("s_addr", 64'(s_addr), 64'(v.addr));
        check("s_wdata", 64'(s_wdata), v.is_dmem ? 64'(v.wdata) : 64'd0);
        check("s_wstrb", 64'(s_wstrb), v.is_dmem ? 64'(v.wstrb) : 64'd0);
        check("s_instr", 64'(s_instr), 64'(!v.is_dmem));
      end
      if (imem_ready || dmem_ready) begin
        seen = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        s_ready = '0;
      end else if (!v.exp_err && cyc == v.delay + 1) begin
        s_ready = '1;
      end
    end
    if (!seen) begin
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      s_ready = '0;
      sb_q.delete();
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("s_valid_trace", 64'(sv_bad), 64'd0);
    tick();
    check("ready_pulse_width", {62'd0, imem_ready, dmem_ready}, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int unsigned n, cyc, cnt;
    sb_t e;
    localparam logic [31:0] M  = 32'h0F0F0F0F;
    localparam logic [31:0] IA = 32'h80000100;
    localparam logic [31:0] DA = 32'h80000200;

    //          dmem  addr          wdata         wstrb dly rdata         sel       err
    vecs[0]  = '{1'b1, 32'h80000010, 32'h0,        4'h0, 2, 32'hDEADBEEF, 5'b10000, 1'b0};
    vecs[1]  = '{1'b1, 32'h01000004, 32'h11111111, 4'hF, 0, 32'h0,        5'b00000, 1'b1};
    vecs[2]  = '{1'b0, 32'h90000000, 32'hCAFEF00D, 4'hF, 0, 32'h0,        5'b00000, 1'b1};
    vecs[3]  = '{1'b1, 32'h00000040, 32'h22222222, 4'hF, 0, 32'h0,        5'b00000, 1'b1};
    vecs[4]  = '{1'b1, 32'h00000040, 32'h33333333, 4'h0, 0, 32'h12345678, 5'b00001, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000007C, 32'hCAFEF00D, 4'hF, 1, 32'h0BADF00D, 5'b00001, 1'b0};
    vecs[6]  = '{1'b0, 32'h00000080, 32'hCAFEF00D, 4'hF, 0, 32'h0,        5'b00000, 1'b1};
    vecs[7]  = '{1'b1, 32'h01000000, 32'h000055AA, 4'h3, 1, 32'h11112222, 5'b00010, 1'b0};
    vecs[8]  = '{1'b1, 32'h0200BFFC, 32'h0,        4'h0, 3, 32'h44445555, 5'b00100, 1'b0};
    vecs[9]  = '{1'b1, 32'h0200C000, 32'h0,        4'h0, 0, 32'h0,        5'b00000, 1'b1};
    vecs[10] = '{1'b0, 32'h03004FFC, 32'hCAFEF00D, 4'hF, 0, 32'h66667777, 5'b01000, 1'b0};
    vecs[11] = '{1'b1, 32'h7FFFFFFC, 32'h0,        4'h0, 0, 32'h0,        5'b00000, 1'b1};
    vecs[12] = '{1'b1, 32'h8FFFFFFC, 32'h000000EE, 4'h1, 1, 32'h99990000, 5'b10000, 1'b0};
    vecs[13] = '{1'b1, 32'hFFFFFFFF, 32'h0,        4'h0, 0, 32'h0,        5'b00000, 1'b1};
    vecs[14] = '{1'b1, 32'h03000000, 32'h0,        4'h0, 0, 32'h13579BDF, 5'b01000, 1'b0};

    reset = 1'b1;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    tick(); tick();
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_bus", {s_instr, s_wstrb, s_addr}, 64'd0);
    check("rst_s_wdata", 64'(s_wdata), 64'd0);
    check("rst_imem_out", {31'd0, imem_ready, imem_error, imem_rdata}, 64'd0);
    check("rst_dmem_out", {31'd0, dmem_ready, dmem_error, dmem_rdata}, 64'd0);
    reset = 1'b0;

    // Contention right after reset: dmem first, then strict alternation while both stay valid.
    imem_addr = IA; dmem_addr = DA; dmem_wdata = '0; dmem_wstrb = '0;
    imem_valid = 1'b1; dmem_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e.is_dmem = (k % 2 == 0);
      e.rdata   = ((k % 2 == 0) ? DA : IA) ^ M;
      e.err     = 1'b0;
      sb_q.push_back(e);
    end
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      tick();
      cyc++;
      s_rdata = '0;
      s_rdata[128 +: 32] = s_addr ^ M;
      s_ready = s_valid;
      if (imem_ready || dmem_ready) begin
        n++;
        if (n == 6) begin
          imem_valid = 1'b0;
          dmem_valid = 1'b0;
        end
      end
    end
    check("contend_count", 64'(n), 64'd6);
    check("contend_cycles", 64'(cyc), 64'd17);
    s_ready = '0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset during a clint BUSY: no response, and a late slave ready is ignored.
    dmem_valid = 1'b1; dmem_addr = 32'h02000010; dmem_wstrb = '0; s_ready = '0;
    tick();
    check("rst_mid_sel", 64'(s_valid), 64'b00100);
    tick();
    reset = 1'b1;
    dmem_valid = 1'b0;
    tick();
    reset = 1'b0;
    s_ready = 5'b00100;
    check("rst_mid_drop", 64'(s_valid), 64'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      s_ready = '0;
      if (imem_ready || dmem_ready || s_valid != '0) cnt++;
    end
    check("rst_mid_quiet", 64'(cnt), 64'd0);
    run_vec('{1'b1, 32'h02000010, 32'h0, 4'h0, 1, 32'h2468ACE0, 5'b00100, 1'b0});

    // Clic slave that never answers on its own.
    dmem_valid = 1'b1; dmem_addr = 32'h03000010; dmem_wstrb = '0; dmem_wdata = '0;
    s_ready = 5'b10111;
    s_rdata = '0;
    s_rdata[96 +: 32] = 32'h77778888;
`ifdef BUS_TIMEOUT_EN
    e.is_dmem = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
    sb_q.push_back(e);
    cnt = 0; cyc = 0; n = 0;
    while (n == 0 && cyc < 40) begin
      tick();
      cyc++;
      if (s_valid == 5'b01000) cnt++;
      if (dmem_ready) begin
        n = 1;
        dmem_valid = 1'b0;
      end
    end
    check("timeout_sel_cycles", 64'(cnt), 64'd8);
    check("timeout_latency", 64'(cyc), 64'd9);
`else
    e.is_dmem = 1'b1; e.rdata = 32'h77778888; e.err = 1'b0;
    sb_q.push_back(e);
    cnt = 0; n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_valid == 5'b01000) cnt++;
      if (dmem_ready || imem_ready) n++;
    end
    check("wait_sel_cycles", 64'(cnt), 64'd20);
    check("wait_no_ready", 64'(n), 64'd0);
    s_ready = '1;
    tick();
    check("wait_then_ready", 64'(dmem_ready), 64'd1);
    dmem_valid = 1'b0;
`endif
    s_ready = '0;
    tick();
    tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, five-slave memory-bus controller for the core.
- Arbitrates between the instruction-fetch port (imem) and the load/store port (dmem), then decodes the granted address against the system map (rom, print, clint, clic, bram).
- Sequences one transaction at a time to the selected slave and returns the response to the granted master.
- Unmapped accesses and ROM writes complete with an error and generate no slave access.

Parameters:
- ROM_BASE, 32'h0, ROM region start (inclusive)
- ROM_TOP, 32'h80, ROM region end (exclusive)
- PRINT_BASE, 32'h1000000 / PRINT_TOP, 32'h1000004, print region
- CLINT_BASE, 32'h2000000 / CLINT_TOP, 32'h200C000, CLINT region
- CLIC_BASE, 32'h3000000 / CLIC_TOP, 32'h3005000, CLIC region
- BRAM_BASE, 32'h80000000 / BRAM_TOP, 32'h90000000, BRAM region
- TIMEOUT_CYCLES, 1024, slave wait limit; used only with BUS_TIMEOUT_EN

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- imem_valid  in  1  fetch request
- imem_addr  in  32  fetch address
- imem_ready  out  1  fetch response pulse
- imem_rdata  out  32  fetch data
- imem_error  out  1  fetch error, qualified by imem_ready
- dmem_valid  in  1  data request
- dmem_addr  in  32  data address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes; 0 = read
- dmem_ready  out  1  data response pulse
- dmem_rdata  out  32  read data
- dmem_error  out  1  data error, qualified by dmem_ready
- s_valid  out  5  one-hot slave select; bit0 rom, bit1 print, bit2 clint, bit3 clic, bit4 bram
- s_instr  out  1  current transaction is a fetch
- s_addr  out  32  shared slave address
- s_wdata  out  32  shared write data
- s_wstrb  out  4  shared strobes; 0 for fetches
- s_ready  in  5  per-slave ready
- s_rdata  in  160  per-slave read data; slave i occupies bits [32i+31:32i]

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = imem, so dmem wins the first contention.
- Region hit: BASE <= addr < TOP, compared as 32-bit unsigned. Regions do not overlap. No hit means unmapped.
- IDLE:
  - Samples both valids.
  - If only one is high, grant it.
  - If both are high, grant the master not in last_grant (strict alternation under contention).
  - Latch the winner's addr, wdata and wstrb, and update last_grant.
  - Next state:
    - unmapped, or rom hit with wstrb != 0 -> ERR
    - any other hit -> BUSY
    - no valid -> stay in IDLE
- BUSY:
  - s_valid = one-hot of the region; s_addr/s_wdata/s_wstrb/s_instr come from the latched values and stay stable.
  - Wait for s_ready of the selected bit; ready bits of other slaves are ignored.
  - On selected ready: register that slave's rdata, error = 0, go to RESP. s_valid drops in the RESP cycle.
- ERR: no s_valid; rdata = 0, error = 1; go to RESP.
- RESP:
  - Granted master's ready = 1 for exactly one cycle, with rdata/error valid; the other master's outputs stay 0.
  - Go to IDLE.
- Latency: request in cycle 0, s_valid in cycle 1. Slave ready in cycle N >= 1 gives master ready in cycle N+1. Error path gives master ready in cycle 2.
- Masters hold valid and address stable until their ready pulse. Valid still high in the IDLE cycle after ready is treated as a new request.
- A request from the losing master stays pending and is granted in the next IDLE cycle, provided its valid is still high.
- Reset asserted mid-transaction: return to IDLE immediately, drop s_valid, suppress the response. A late s_ready after reset is ignored.
- s_wstrb and s_wdata are 0 whenever s_instr = 1.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to BUSY and increments each BUSY cycle without selected ready.
  - When the count reaches TIMEOUT_CYCLES, drop s_valid and go to RESP with error = 1, rdata = 0.
  - A selected ready arriving in the same cycle wins, giving a normal completion.
- Not defined: BUSY waits indefinitely; no counter logic is present.

Test Plan:
- dmem read 32'h80000010, bram ready 2 cycles after s_valid, rdata 32'hDEADBEEF -> s_valid = 5'b10000, dmem_ready pulse one cycle after bram ready, dmem_rdata = 32'hDEADBEEF, dmem_error = 0.
- imem and dmem valid in the same cycle after reset, both to bram -> dmem served first, then imem. Both held continuously -> grants alternate dmem, imem, dmem, ...
- dmem write 32'h1000004 (one past print) and imem fetch 32'h90000000 -> error = 1, rdata = 0, ready in cycle 2, s_valid never asserted.
- dmem write wstrb 4'hF to 32'h40 (rom) -> error response, no s_valid. dmem read 32'h40 -> rom selected, s_wstrb = 0.
- Reset asserted while in BUSY on a clint access, clint ready arrives the cycle after -> no master ready, s_valid = 0, next request proceeds normally.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 8, clic never ready -> s_valid high 8 cycles, then dmem_ready with dmem_error = 1.
